// File: rtl/adam_periph_uart_autobaud.sv
// UART auto-baud calibrator.
// Measures a 0x55 sync character on the raw rx line and derives the receiver
// divider (clock cycles per bit).  The span from the start-bit falling edge to
// the bit-7 falling edge is eight bit periods; that count is rounded and
// divided by eight.  A peripheral pause handshake freezes the block.
module adam_periph_uart_autobaud #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_COUNT  = 2**20,
    parameter int MIN_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause_req,
    output logic                  pause_ack,
    input  logic                  start,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] baud_rate,
    output logic                  rx_enable,
    output logic                  locked,
    output logic                  error
);

    // Counter is wide enough to hold MAX_COUNT itself so it can saturate there.
    localparam int             CW      = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_COUNT);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_WAIT_FALL, S_MEASURE,
        S_WAIT_STOP, S_LOCKED, S_ERROR, S_PAUSED
    } state_t;

    state_t                state_r, state_nx;
    state_t                ret_r, ret_nx;
    logic [CW-1:0]         cnt_r, cnt_nx, cnt_inc_s;
    logic [CW-1:0]         meas_r, meas_nx;
    logic [2:0]            edge_cnt_r, edge_nx;
    logic [3:0]            idle_cnt_r, idle_nx;
    logic [DATA_WIDTH-1:0] baud_rate_r, baud_nx;
    logic                  locked_r, locked_nx;
    logic                  error_r, error_nx;
    logic                  rx_enable_r, rx_enable_nx;
    logic                  pause_ack_r, pause_ack_nx;
    logic                  rx_meta_r, rx_sync_r, rx_prev_r;
    logic                  fall_s, rise_s, measuring_s;
    logic [CW:0]           sum_s, div_s;

    assign fall_s      = rx_prev_r & ~rx_sync_r;
    assign rise_s      = ~rx_prev_r & rx_sync_r;
    assign measuring_s = (state_r == S_WAIT_IDLE) || (state_r == S_WAIT_FALL) ||
                         (state_r == S_MEASURE)   || (state_r == S_WAIT_STOP);
    assign cnt_inc_s   = (cnt_r == MAX_CNT) ? cnt_r : cnt_r + CW'(1);
    // Round to nearest: (N + 4) / 8.
    assign sum_s       = {1'b0, meas_r} + (CW+1)'(4);
    assign div_s       = sum_s >> 3'd3;

    assign baud_rate = baud_rate_r;
    assign locked    = locked_r;
    assign error     = error_r;
    assign rx_enable = rx_enable_r;
    assign pause_ack = pause_ack_r;

    // Two-flop synchronizer on the asynchronous rx line plus a delayed copy for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Next-state, datapath and output decode; pause beats start, start beats everything else.
    always_comb begin
        state_nx = state_r;
        ret_nx   = ret_r;
        cnt_nx   = cnt_r;
        meas_nx  = meas_r;
        edge_nx  = edge_cnt_r;
        idle_nx  = idle_cnt_r;
        baud_nx  = baud_rate_r;

        if (pause_req && (state_r != S_PAUSED)) begin
            // A measurement in flight is abandoned; resume lands in IDLE.
            state_nx = S_PAUSED;
            ret_nx   = measuring_s ? S_IDLE : state_r;
        end else if (start && (state_r != S_PAUSED)) begin
            state_nx = S_WAIT_IDLE;
            cnt_nx   = '0;
            edge_nx  = 3'd0;
            idle_nx  = 4'd0;
        end else begin
            case (state_r)
                S_WAIT_IDLE: begin
                    cnt_nx = cnt_inc_s;
                    if (rx_sync_r) begin
                        if (idle_cnt_r == 4'd15) begin
                            state_nx = S_WAIT_FALL;
                            idle_nx  = 4'd0;
                        end else begin
                            idle_nx = idle_cnt_r + 4'd1;
                        end
                    end else begin
                        idle_nx = 4'd0;
                    end
                end
                S_WAIT_FALL: begin
                    if (cnt_r == MAX_CNT) begin
                        state_nx = S_ERROR;
                    end else if (fall_s) begin
                        state_nx = S_MEASURE;
                        cnt_nx   = CW'(1);
                        edge_nx  = 3'd0;
                    end else begin
                        cnt_nx = cnt_inc_s;
                    end
                end
                S_MEASURE: begin
                    if (cnt_r == MAX_CNT) begin
                        state_nx = S_ERROR;
                    end else begin
                        cnt_nx = cnt_inc_s;
                        if (fall_s) begin
                            edge_nx = edge_cnt_r + 3'd1;
                            if (edge_cnt_r == 3'd3) begin
                                meas_nx  = cnt_r;
                                state_nx = S_WAIT_STOP;
                            end else begin
                                meas_nx = meas_r;
                            end
                        end else begin
                            edge_nx = edge_cnt_r;
                        end
                    end
                end
                S_WAIT_STOP: begin
                    if (cnt_r == MAX_CNT) begin
                        state_nx = S_ERROR;
                    end else if (rise_s) begin
                        if (div_s < (CW+1)'(MIN_DIV)) begin
                            state_nx = S_ERROR;
                        end else begin
                            state_nx = S_LOCKED;
                            baud_nx  = DATA_WIDTH'(div_s);
                        end
                    end else begin
                        cnt_nx = cnt_inc_s;
                    end
                end
                S_PAUSED: begin
                    if (!pause_req) begin
                        state_nx = ret_r;
                    end else begin
                        state_nx = S_PAUSED;
                    end
                end
                S_IDLE, S_LOCKED, S_ERROR: begin
                    state_nx = state_r;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end

        // Status outputs survive a pause taken from LOCKED or ERROR.
        locked_nx    = (state_nx == S_LOCKED) ||
                       ((state_nx == S_PAUSED) && (ret_nx == S_LOCKED));
        error_nx     = (state_nx == S_ERROR) ||
                       ((state_nx == S_PAUSED) && (ret_nx == S_ERROR));
        rx_enable_nx = (state_nx == S_LOCKED);
        pause_ack_nx = (state_nx == S_PAUSED);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            ret_r       <= S_IDLE;
            cnt_r       <= '0;
            meas_r      <= '0;
            edge_cnt_r  <= 3'd0;
            idle_cnt_r  <= 4'd0;
            baud_rate_r <= '0;
            locked_r    <= 1'b0;
            error_r     <= 1'b0;
            rx_enable_r <= 1'b0;
            pause_ack_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            ret_r       <= ret_nx;
            cnt_r       <= cnt_nx;
            meas_r      <= meas_nx;
            edge_cnt_r  <= edge_nx;
            idle_cnt_r  <= idle_nx;
            baud_rate_r <= baud_nx;
            locked_r    <= locked_nx;
            error_r     <= error_nx;
            rx_enable_r <= rx_enable_nx;
            pause_ack_r <= pause_ack_nx;
        end
    end

endmodule

// File: tb/tb_adam_periph_uart_autobaud.sv
// Bench for the UART auto-baud calibrator: randomized 0x55 frames with
// per-bit length jitter, scoreboard of expected lock/error outcomes, and
// directed pause / restart / reset / timeout scenarios.
module tb_adam_periph_uart_autobaud;

    localparam int TB_MAX = 20000;
    localparam int TB_MIN = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause_req;
    logic        pause_ack;
    logic        start;
    logic        rx;
    logic [31:0] baud_rate;
    logic        rx_enable;
    logic        locked;
    logic        error;

    typedef struct {
        logic        lk;
        logic        er;
        logic [31:0] baud;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_baud = 0;
    logic [7:0]  sync_char = 8'h55;

    adam_periph_uart_autobaud #(
        .DATA_WIDTH(32),
        .MAX_COUNT (TB_MAX),
        .MIN_DIV   (TB_MIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pause_req(pause_req),
        .pause_ack(pause_ack),
        .start    (start),
        .rx       (rx),
        .baud_rate(baud_rate),
        .rx_enable(rx_enable),
        .locked   (locked),
        .error    (error)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Frame bit i: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return sync_char[i-1];
    endfunction

    // Monitor: every new lock or error indication is one DUT result.
    initial begin
        logic lk_q, er_q;
        exp_t e;
        lk_q = 1'b0;
        er_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ((locked && !lk_q) || (error && !er_q))) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: locked=%0d error=%0d baud=%0d", locked, error, baud_rate);
                end else begin
                    e = sb.pop_front();
                    chk("result_locked", {31'd0, locked}, {31'd0, e.lk});
                    chk("result_error", {31'd0, error}, {31'd0, e.er});
                    chk("result_rx_enable", {31'd0, rx_enable}, {31'd0, e.lk});
                    chk("result_baud", baud_rate, e.baud);
                end
            end
            lk_q = locked;
            er_q = error;
        end
    end

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (sb.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: %0d results outstanding after %0d cycles, required 0", sb.size(), bound);
            sb.delete();
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_partial(input int t, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = frame_bit(i);
            repeat (t) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // Full calibration: the model sums the first eight bit periods and rounds /8.
    task automatic run_cal(input int t, input bit jit);
        int   lens[10];
        int   n;
        int   div;
        int   tot;
        exp_t e;
        n = 0;
        tot = 0;
        for (int i = 0; i < 10; i++) begin
            lens[i] = t + (jit ? int'($urandom_range(0, 1)) : 0);
            tot += lens[i];
            if (i < 8) n += lens[i];
        end
        div = (n + 4) / 8;
        if (div < TB_MIN) begin
            e = '{lk: 1'b0, er: 1'b1, baud: model_baud};
        end else begin
            model_baud = div;
            e = '{lk: 1'b1, er: 1'b0, baud: div};
        end
        sb.push_back(e);
        rx = 1'b1;
        pulse_start();
        repeat ($urandom_range(20, 60)) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx = frame_bit(i);
            repeat (lens[i]) @(negedge clk);
        end
        rx = 1'b1;
        wait_done(tot + 500);
    endtask

    initial begin
        rst       = 1'b1;
        pause_req = 1'b0;
        start     = 1'b0;
        rx        = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_baud", baud_rate, 32'd0);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        chk("reset_rx_enable", {31'd0, rx_enable}, 32'd0);
        chk("reset_pause_ack", {31'd0, pause_ack}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal 115200 baud at 50 MHz.
        run_cal(434, 1'b0);

        // Randomized rates with per-bit jitter, including some below the divider floor.
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 3) == 0) run_cal(int'($urandom_range(8, 15)), 1'b1);
            else                           run_cal(int'($urandom_range(16, 600)), 1'b1);
        end

        // Divider below floor: error, divider unchanged.
        run_cal(10, 1'b0);

        // Pause while locked: outputs held, receiver gated, start ignored.
        run_cal(434, 1'b0);
        @(negedge clk);
        pause_req = 1'b1;
        @(negedge clk);
        chk("pause_lock_ack", {31'd0, pause_ack}, 32'd1);
        chk("pause_lock_locked", {31'd0, locked}, 32'd1);
        chk("pause_lock_rx_enable", {31'd0, rx_enable}, 32'd0);
        chk("pause_lock_baud", baud_rate, model_baud);
        pulse_start();
        repeat (5) @(negedge clk);
        pause_req = 1'b0;
        @(negedge clk);
        chk("resume_lock_ack", {31'd0, pause_ack}, 32'd0);
        chk("resume_lock_rx_enable", {31'd0, rx_enable}, 32'd1);
        chk("resume_lock_locked", {31'd0, locked}, 32'd1);

        // Pause mid-measurement: abort, resume idle, then a slow calibration.
        pulse_start();
        repeat (30) @(negedge clk);
        send_partial(200, 4);
        pause_req = 1'b1;
        @(negedge clk);
        chk("pause_meas_ack", {31'd0, pause_ack}, 32'd1);
        chk("pause_meas_rx_enable", {31'd0, rx_enable}, 32'd0);
        repeat (20) @(negedge clk);
        pause_req = 1'b0;
        @(negedge clk);
        chk("resume_meas_ack", {31'd0, pause_ack}, 32'd0);
        repeat (2) @(negedge clk);
        chk("resume_meas_locked", {31'd0, locked}, 32'd0);
        chk("resume_meas_error", {31'd0, error}, 32'd0);
        chk("resume_meas_baud", baud_rate, model_baud);
        run_cal(1041, 1'b0);

        // Restart with start in the middle of a measurement.
        pulse_start();
        repeat (30) @(negedge clk);
        send_partial(250, 5);
        run_cal(300, 1'b0);

        // Reset mid-measurement clears everything, then lock again.
        pulse_start();
        repeat (30) @(negedge clk);
        send_partial(150, 4);
        rst = 1'b1;
        #1;
        chk("midreset_baud", baud_rate, 32'd0);
        chk("midreset_locked", {31'd0, locked}, 32'd0);
        chk("midreset_rx_enable", {31'd0, rx_enable}, 32'd0);
        chk("midreset_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_baud = 0;
        repeat (3) @(negedge clk);
        run_cal(434, 1'b0);

        // No falling edge ever arrives: timeout error, divider kept.
        sb.push_back('{lk: 1'b0, er: 1'b1, baud: model_baud});
        rx = 1'b1;
        pulse_start();
        wait_done(TB_MAX + 2000);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
